// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibits the clock, requests to send,
// shifts out start/data/parity/stop on device clock edges and samples the ACK bit.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_in,
    input  logic       kdata_in,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);
    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_WAIT_IDLE
    } state_t;

    // Index 0 = clock line, index 1 = data line.
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    filt;
    logic [FW-1:0] fcnt [2];
    logic          kclk_prev;
    logic          kclk_f;
    logic          kdata_f;
    logic          fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= 2'b11;
            sync_b    <= 2'b11;
            filt      <= 2'b11;
            kclk_prev <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync_a    <= {kdata_in, kclk_in};
            sync_b    <= sync_a;
            kclk_prev <= filt[0];
            // A run of FILTER_LEN samples that disagree with the output flips it.
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync_b[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign kclk_f  = filt[0];
    assign kdata_f = filt[1];
    assign fall    = kclk_prev & ~kclk_f;

    state_t        state;
    state_t        state_d;
    logic [7:0]    data_q;
    logic          par_q;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic [3:0]    idx;
    logic [15:0]   frame;
    logic          counting;
    logic          tmo_hit;
    logic          accept;
    logic          done_set;
    logic          tmo_set;

    // Bit n of the frame sits at frame[n]: start, data LSB first, parity, stop.
    assign frame    = {5'b11111, 1'b1, par_q, data_q, 1'b0};
    assign counting = (state == S_REQ) || (state == S_SHIFT) || (state == S_WAIT_IDLE);
    assign tmo_hit  = (tcnt == TW'(TIMEOUT_CYCLES - 1)) && !fall;

    always_comb begin
        state_d  = state;
        tx_ready = 1'b0;
        kclk_oe  = 1'b0;
        kdata_oe = 1'b0;
        accept   = 1'b0;
        done_set = 1'b0;
        tmo_set  = 1'b0;
        case (state)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    accept  = 1'b1;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                kclk_oe = 1'b1;
                if (icnt == '0) begin
                    kdata_oe = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                kdata_oe = 1'b1;
                if (fall) begin
                    state_d = S_SHIFT;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                kdata_oe = ~frame[idx];
                if (fall) begin
                    if (idx == 4'd10) state_d = S_WAIT_IDLE;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (kclk_f && kdata_f) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            data_q     <= '0;
            par_q      <= 1'b0;
            icnt       <= '0;
            tcnt       <= '0;
            idx        <= '0;
            tx_done    <= 1'b0;
            tx_ack_err <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state      <= state_d;
            tx_done    <= done_set;
            tx_timeout <= tmo_set;
            if (accept) begin
                data_q     <= tx_data;
                par_q      <= ~^tx_data;
                icnt       <= IW'(INHIBIT_CYCLES - 1);
                idx        <= '0;
                tx_ack_err <= 1'b0;
            end else if (state == S_INHIBIT && icnt != '0) begin
                icnt <= icnt - 1'b1;
            end
            // Edge 1 (in REQ) selects bit 1; edge 11 saturates the index and takes the ACK.
            if (fall && (state == S_REQ || state == S_SHIFT) && idx != 4'd11) begin
                idx <= idx + 4'd1;
            end
            if (fall && state == S_SHIFT && idx == 4'd10) begin
                tx_ack_err <= kdata_f;
            end
            if (state_d != state || fall || !counting) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end
endmodule
